// File: rtl/clockport_seq.sv
// Clockport access sequencer: turns a 68000 access at $D8xxxx into timed
// chip-select / read / write strobes on the clockport and hands back a DTACK request.
module clockport_seq #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       _AS,
  input  logic       R_W,
  input  logic       _LDS,
  input  logic [7:0] AH,
  input  logic [7:0] D_IN,
  input  logic [7:0] DD_IN,
  output logic       _SPARE_CS,
  output logic       _IORD,
  output logic       _IOWR,
  output logic       CP_DTACK,
  output logic       CP_OVR,
  output logic [7:0] RDATA,
  output logic [7:0] WDATA,
  output logic       D0_OE,
  output logic       DD8_OE
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_dir;
  logic       r_dtack;
  logic       r_cs;
  logic       r_iord;
  logic       r_iowr;
  logic       r_ddoe;
  logic [7:0] r_rdata;
  logic [7:0] r_wdata;

  logic w_hit;
  logic w_toIdle;

  assign w_hit = (AH == 8'hD8);
  // Any non-idle state returns to IDLE once _AS is seen high: abort or normal end.
  assign w_toIdle = _AS && (r_state != IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_dir   <= 1'b1;
      r_dtack <= 1'b0;
      r_cs    <= 1'b1;
      r_iord  <= 1'b1;
      r_iowr  <= 1'b1;
      r_ddoe  <= 1'b0;
      r_rdata <= 8'h00;
      r_wdata <= 8'h00;
    end else if (w_toIdle) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_dtack <= 1'b0;
      r_cs    <= 1'b1;
      r_iord  <= 1'b1;
      r_iowr  <= 1'b1;
      r_ddoe  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!_AS && w_hit) begin
            r_state <= SETUP;
            r_cnt   <= SETUP_LOAD;
            r_dir   <= R_W;
            r_wdata <= D_IN;
            r_cs    <= 1'b0;
            r_ddoe  <= !R_W;
          end
        end
        SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state <= STROBE;
            r_cnt   <= STROBE_LOAD;
            r_iord  <= !r_dir;
            r_iowr  <= r_dir;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state <= HOLD;
            r_cnt   <= HOLD_LOAD;
            r_iord  <= 1'b1;
            r_iowr  <= 1'b1;
            r_dtack <= 1'b1;
            if (r_dir) r_rdata <= DD_IN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_cs    <= 1'b1;
            r_ddoe  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign CP_OVR    = w_hit;
  assign _SPARE_CS = r_cs;
  assign _IORD     = r_iord;
  assign _IOWR     = r_iowr;
  assign DD8_OE    = r_ddoe;
  assign RDATA     = r_rdata;
  assign WDATA     = r_wdata;
  assign CP_DTACK  = r_dtack && !_AS;
  assign D0_OE     = r_dtack && r_dir && !_AS && !_LDS;

endmodule

// File: tb/tb_clockport_seq.sv
// Bench for clockport_seq: three timing variants driven in parallel, checked every
// cycle against an edge-count model of the access, plus hand-computed expectations.
module tb_clockport_seq;

  localparam int NI = 3;

  function automatic int setupOf(input int i);
    return (i == 2) ? 3 : 1;
  endfunction
  function automatic int strobeOf(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
  endfunction
  function automatic int holdOf(input int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int lenOf(input int i);
    return setupOf(i) + strobeOf(i) + holdOf(i);
  endfunction

  logic       clk;
  logic       rst;
  logic       asN;
  logic       rw;
  logic       ldsN;
  logic [7:0] ah;
  logic [7:0] dIn;
  logic [7:0] ddIn;

  logic       csN    [NI];
  logic       iordN  [NI];
  logic       iowrN  [NI];
  logic       cpDtack[NI];
  logic       cpOvr  [NI];
  logic [7:0] rData  [NI];
  logic [7:0] wData  [NI];
  logic       d0Oe   [NI];
  logic       dd8Oe  [NI];

  int total;
  int bad;
  bit checkOn;

  // Model: k counts edges since the access started (0 = idle, len+1 = waiting for _AS high)
  int         k   [NI];
  logic       mDir[NI];
  logic [7:0] mR  [NI];
  logic [7:0] mW  [NI];

  int csCnt[NI], iordCnt[NI], iowrCnt[NI], ddoeCnt[NI];
  int dtackFirst[NI], d0oeCnt[NI], ovrCnt[NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gDut
    clockport_seq #(
      .SETUP_CYC (setupOf(g)),
      .STROBE_CYC(strobeOf(g)),
      .HOLD_CYC  (holdOf(g))
    ) dut (
      .CLK      (clk),
      .RESET    (rst),
      ._AS      (asN),
      .R_W      (rw),
      ._LDS     (ldsN),
      .AH       (ah),
      .D_IN     (dIn),
      .DD_IN    (ddIn),
      ._SPARE_CS(csN[g]),
      ._IORD    (iordN[g]),
      ._IOWR    (iowrN[g]),
      .CP_DTACK (cpDtack[g]),
      .CP_OVR   (cpOvr[g]),
      .RDATA    (rData[g]),
      .WDATA    (wData[g]),
      .D0_OE    (d0Oe[g]),
      .DD8_OE   (dd8Oe[g])
    );
  end

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s inst%0d: got %0h want %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Advance the access model on every clock edge using the inputs seen at that edge
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        k[i]    <= 0;
        mDir[i] <= 1'b1;
        mR[i]   <= 8'h00;
        mW[i]   <= 8'h00;
      end else if (k[i] == 0) begin
        if (!asN && ah == 8'hD8) begin
          k[i]    <= 1;
          mDir[i] <= rw;
          mW[i]   <= dIn;
        end
      end else if (asN) begin
        k[i] <= 0;
      end else if (k[i] <= lenOf(i)) begin
        if (k[i] == setupOf(i) + strobeOf(i) && mDir[i]) mR[i] <= ddIn;
        k[i] <= k[i] + 1;
      end
    end
  end

  // Compare every output of every instance against the model mid-cycle
  always @(negedge clk) begin
    if (checkOn) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput("SPARE_CS", i, 32'(csN[i]), 32'(!(k[i] >= 1 && k[i] <= lenOf(i))));
        checkOutput("IORD", i, 32'(iordN[i]), 32'(!(mDir[i] && k[i] > setupOf(i) &&
                    k[i] <= setupOf(i) + strobeOf(i))));
        checkOutput("IOWR", i, 32'(iowrN[i]), 32'(!(!mDir[i] && k[i] > setupOf(i) &&
                    k[i] <= setupOf(i) + strobeOf(i))));
        checkOutput("DD8_OE", i, 32'(dd8Oe[i]), 32'(!mDir[i] && k[i] >= 1 && k[i] <= lenOf(i)));
        checkOutput("CP_DTACK", i, 32'(cpDtack[i]),
                    32'(k[i] > setupOf(i) + strobeOf(i) && !asN));
        checkOutput("D0_OE", i, 32'(d0Oe[i]),
                    32'(k[i] > setupOf(i) + strobeOf(i) && mDir[i] && !asN && !ldsN));
        checkOutput("CP_OVR", i, 32'(cpOvr[i]), 32'(ah == 8'hD8));
        checkOutput("RDATA", i, 32'(rData[i]), 32'(mR[i]));
        checkOutput("WDATA", i, 32'(wData[i]), 32'(mW[i]));
      end
    end
  end

  // One access: _AS low for lowEdges sampled edges, then high for gap+1 edges
  task automatic applyStimulus(input logic [7:0] a, input logic r, input logic [7:0] d,
                               input logic [7:0] dd, input logic lds, input int lowEdges,
                               input int gap);
    for (int i = 0; i < NI; i++) begin
      csCnt[i] = 0; iordCnt[i] = 0; iowrCnt[i] = 0; ddoeCnt[i] = 0;
      dtackFirst[i] = 0; d0oeCnt[i] = 0; ovrCnt[i] = 0;
    end
    @(posedge clk);
    #2;
    asN = 1'b0; ah = a; rw = r; dIn = d; ddIn = dd; ldsN = lds;
    for (int c = 1; c <= lowEdges; c++) begin
      @(posedge clk);
      #3;
      for (int i = 0; i < NI; i++) begin
        if (!csN[i]) csCnt[i]++;
        if (!iordN[i]) iordCnt[i]++;
        if (!iowrN[i]) iowrCnt[i]++;
        if (dd8Oe[i]) ddoeCnt[i]++;
        if (d0Oe[i]) d0oeCnt[i]++;
        if (cpOvr[i]) ovrCnt[i]++;
        if (cpDtack[i] && dtackFirst[i] == 0) dtackFirst[i] = c;
      end
    end
    asN = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    total = 0; bad = 0; checkOn = 1'b0;
    rst = 1'b0; asN = 1'b1; rw = 1'b1; ldsN = 1'b1;
    ah = 8'h00; dIn = 8'h00; ddIn = 8'h00;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 checkOn = 1'b1;
    #1;
    checkOutput("rst_cs", 0, 32'(csN[0]), 32'd1);
    checkOutput("rst_iord", 0, 32'(iordN[0]), 32'd1);
    checkOutput("rst_iowr", 0, 32'(iowrN[0]), 32'd1);
    checkOutput("rst_dtack", 0, 32'(cpDtack[0]), 32'd0);
    checkOutput("rst_rdata", 0, 32'(rData[0]), 32'h00);
    @(posedge clk);
    #2 rst = 1'b0;

    // Default-timing read of $D80001
    applyStimulus(8'hD8, 1'b1, 8'h00, 8'h5A, 1'b0, 10, 1);
    checkOutput("rd_cs_cycles", 0, 32'(csCnt[0]), 32'd6);
    checkOutput("rd_iord_cycles", 0, 32'(iordCnt[0]), 32'd4);
    checkOutput("rd_iowr_cycles", 0, 32'(iowrCnt[0]), 32'd0);
    checkOutput("rd_dtack_first", 0, 32'(dtackFirst[0]), 32'd6);
    checkOutput("rd_d0oe_cycles", 0, 32'(d0oeCnt[0]), 32'd5);
    checkOutput("rd_ovr_cycles", 0, 32'(ovrCnt[0]), 32'd10);
    checkOutput("rd_rdata", 0, 32'(rData[0]), 32'h5A);
    checkOutput("rd_cs_cycles", 1, 32'(csCnt[1]), 32'd3);
    checkOutput("rd_dtack_first", 1, 32'(dtackFirst[1]), 32'd3);
    checkOutput("rd_cs_cycles", 2, 32'(csCnt[2]), 32'd7);
    checkOutput("rd_iord_cycles", 2, 32'(iordCnt[2]), 32'd2);
    checkOutput("rd_dtack_first", 2, 32'(dtackFirst[2]), 32'd6);

    // Default-timing write of $D80001
    applyStimulus(8'hD8, 1'b0, 8'hA5, 8'hFF, 1'b0, 10, 1);
    checkOutput("wr_wdata", 0, 32'(wData[0]), 32'hA5);
    checkOutput("wr_iowr_cycles", 0, 32'(iowrCnt[0]), 32'd4);
    checkOutput("wr_iord_cycles", 0, 32'(iordCnt[0]), 32'd0);
    checkOutput("wr_ddoe_cycles", 0, 32'(ddoeCnt[0]), 32'd6);
    checkOutput("wr_d0oe_cycles", 0, 32'(d0oeCnt[0]), 32'd0);
    checkOutput("wr_rdata_kept", 0, 32'(rData[0]), 32'h5A);

    // Accesses outside the clockport window
    applyStimulus(8'hD9, 1'b1, 8'h00, 8'h12, 1'b0, 6, 1);
    checkOutput("d9_cs_cycles", 0, 32'(csCnt[0]), 32'd0);
    checkOutput("d9_ovr_cycles", 0, 32'(ovrCnt[0]), 32'd0);
    checkOutput("d9_dtack_first", 0, 32'(dtackFirst[0]), 32'd0);
    applyStimulus(8'hC0, 1'b0, 8'h34, 8'h12, 1'b0, 6, 1);
    checkOutput("c0_cs_cycles", 0, 32'(csCnt[0]), 32'd0);
    checkOutput("c0_iowr_cycles", 0, 32'(iowrCnt[0]), 32'd0);

    // _AS released during STROBE of the default instance
    applyStimulus(8'hD8, 1'b1, 8'h00, 8'h33, 1'b0, 3, 1);
    #1;
    checkOutput("abort_iord", 0, 32'(iordN[0]), 32'd1);
    checkOutput("abort_rdata", 0, 32'(rData[0]), 32'h5A);
    checkOutput("abort_dtack_first", 0, 32'(dtackFirst[0]), 32'd0);
    checkOutput("abort_rdata", 1, 32'(rData[1]), 32'h33);
    checkOutput("abort_rdata", 2, 32'(rData[2]), 32'h5A);

    // Reset pulsed mid-STROBE of a write releases outputs without a clock edge
    @(posedge clk);
    #2 asN = 1'b0; ah = 8'hD8; rw = 1'b0; dIn = 8'h77;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("mid_iowr", 0, 32'(iowrN[0]), 32'd0);
    rst = 1'b1; asN = 1'b1;
    #1;
    checkOutput("rstmid_iowr", 0, 32'(iowrN[0]), 32'd1);
    checkOutput("rstmid_ddoe", 0, 32'(dd8Oe[0]), 32'd0);
    checkOutput("rstmid_cs", 0, 32'(csN[0]), 32'd1);
    checkOutput("rstmid_wdata", 0, 32'(wData[0]), 32'h00);
    @(posedge clk);
    #2 rst = 1'b0;

    // Back-to-back reads with one _AS-high cycle between
    applyStimulus(8'hD8, 1'b1, 8'h00, 8'h11, 1'b0, 4, 0);
    checkOutput("b2b1_iord_cycles", 1, 32'(iordCnt[1]), 32'd1);
    checkOutput("b2b1_rdata", 1, 32'(rData[1]), 32'h11);
    applyStimulus(8'hD8, 1'b1, 8'h00, 8'h22, 1'b1, 4, 1);
    checkOutput("b2b2_iord_cycles", 1, 32'(iordCnt[1]), 32'd1);
    checkOutput("b2b2_cs_cycles", 1, 32'(csCnt[1]), 32'd3);
    checkOutput("b2b2_rdata", 1, 32'(rData[1]), 32'h22);

    // Random accesses, aborts and resets checked by the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
      applyStimulus(($urandom_range(0, 2) != 0) ? 8'hD8 : 8'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom), 1'($urandom),
                    int'($urandom_range(1, 14)), int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
